vector_mac_unit: RTL

- Downstream consumer of the VECTOR_LEN-bank data RAM in the CNN accelerator.
- Each accepted beat delivers VECTOR_LEN signed data words in parallel, normally qualified by the RAM read acknowledge, plus a matching weight vector.
- The block computes their dot product and accumulates over a programmed number of beats.
- It then presents one signed accumulated result on a valid/ready handshake to the next stage (activation/writeback).

---
 rtl/cnn_pkg.sv | 30 +++
 rtl/vec_dot_pipe.sv | 64 ++++++
 rtl/vec_lane_mul.sv | 24 ++
 rtl/vector_mac_unit.sv | 94 +++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator datapath blocks.
//   - default lane count / word widths used by the MAC path
//   - MAC controller state encoding
//   - lane-slice helper for flat packed lane vectors
package cnn_pkg;

  localparam int VECTOR_LEN_DEF = 8;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ACC_WIDTH_DEF  = 80;
  localparam int LEN_WIDTH_DEF  = 16;

  localparam logic [1:0] ENC_IDLE   = 2'd0;
  localparam logic [1:0] ENC_ACCUM  = 2'd1;
  localparam logic [1:0] ENC_DRAIN  = 2'd2;
  localparam logic [1:0] ENC_OUTPUT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ENC_IDLE,
    ACCUM  = ENC_ACCUM,
    DRAIN  = ENC_DRAIN,
    OUTPUT = ENC_OUTPUT
  } macState_e;

  // LSB position of a lane inside a flat vector: lane i lives at
  // [laneLsb(i, w) +: w].
  function automatic int laneLsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/vec_dot_pipe.sv
// Two-stage dot-product pipe: S1 lane products, S2 reduced lane sum.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears valids)
//   valid        - accept data/weight vectors this cycle
//   data, weight - VECTOR_LEN signed lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s1Valid      - S1 holds products
//   sum          - S2 lane sum, sign-extended to ACC_WIDTH
//   sumValid     - S2 holds a sum
module vec_dot_pipe
  import cnn_pkg::*;
#(
  parameter int VECTOR_LEN = VECTOR_LEN_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid,
  input  logic [VECTOR_LEN*DATA_WIDTH-1:0] data,
  input  logic [VECTOR_LEN*DATA_WIDTH-1:0] weight,
  output logic                             s1Valid,
  output logic signed [ACC_WIDTH-1:0]      sum,
  output logic                             sumValid
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(VECTOR_LEN);

  // vldPipe[0]: S1 products valid, vldPipe[1]: S2 sum valid
  logic [1:0]               vldPipe;
  logic signed [PROD_W-1:0] prod [VECTOR_LEN];
  logic signed [SUM_W-1:0]  treeSum;
  logic signed [SUM_W-1:0]  sumQ;

  for (genvar i = 0; i < VECTOR_LEN; i++) begin : gLane
    vec_lane_mul #(.DATA_WIDTH(DATA_WIDTH)) uMul (
      .clk  (clk),
      .en   (valid),
      .a    (data[laneLsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .b    (weight[laneLsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .prod (prod[i])
    );
  end

  // Lane reduction; SUM_W carries enough growth that it never overflows.
  always_comb begin
    treeSum = '0;
    for (int i = 0; i < VECTOR_LEN; i++) treeSum = treeSum + SUM_W'(prod[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) vldPipe <= '0;
    else     vldPipe <= {vldPipe[0], valid};
  end

  always_ff @(posedge clk) begin
    if (vldPipe[0]) sumQ <= treeSum;
  end

  assign s1Valid  = vldPipe[0];
  assign sumValid = vldPipe[1];
  assign sum      = ACC_WIDTH'(sumQ);

endmodule

// File: rtl/vec_lane_mul.sv
// One lane of the S1 multiply stage: registered signed product.
// Ports:
//   clk  - clock
//   en   - capture a new product this cycle
//   a, b - signed operands (DATA_WIDTH)
//   prod - registered signed product (2*DATA_WIDTH)
module vec_lane_mul #(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic signed [DATA_WIDTH-1:0]   a,
  input  logic signed [DATA_WIDTH-1:0]   b,
  output logic signed [2*DATA_WIDTH-1:0] prod
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  // Data register needs no reset; its valid bit lives in vec_dot_pipe.
  always_ff @(posedge clk) begin
    if (en) prod <= PROD_W'(a) * PROD_W'(b);
  end

endmodule

// File: rtl/vector_mac_unit.sv
// Vector multiply-accumulate: dot product of data and weight vectors,
// accumulated over a programmed number of beats, result on valid/ready.
// Ports:
//   clkIn, rstIn          - clock, synchronous active-high reset
//   startIn, lenIn        - start pulse and beat count (sampled on accepted start)
//   validIn               - beat valid (RAM rdAck)
//   dataIn, weightIn      - VECTOR_LEN signed lanes each
//   busyOut               - accepted start until result handshake
//   resultOut             - signed accumulated dot product
//   resultValidOut        - result valid
//   resultReadyIn         - consumer ready
module vector_mac_unit
  import cnn_pkg::*;
#(
  parameter int VECTOR_LEN = VECTOR_LEN_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                             clkIn,
  input  logic                             rstIn,
  input  logic                             startIn,
  input  logic [LEN_WIDTH-1:0]             lenIn,
  input  logic                             validIn,
  input  logic [VECTOR_LEN*DATA_WIDTH-1:0] dataIn,
  input  logic [VECTOR_LEN*DATA_WIDTH-1:0] weightIn,
  output logic                             busyOut,
  output logic [ACC_WIDTH-1:0]             resultOut,
  output logic                             resultValidOut,
  input  logic                             resultReadyIn
);

  macState_e                   state, stateNext;
  logic [LEN_WIDTH-1:0]        remaining;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        startAccept;
  logic                        beatAccept;
  logic                        s1Valid;
  logic                        sumValid;
  logic signed [ACC_WIDTH-1:0] sum;

  assign startAccept = (state == IDLE) && startIn;
  assign beatAccept  = (state == ACCUM) && validIn && (remaining != '0);

  vec_dot_pipe #(
    .VECTOR_LEN (VECTOR_LEN),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) uPipe (
    .clk      (clkIn),
    .rst      (rstIn),
    .valid    (beatAccept),
    .data     (dataIn),
    .weight   (weightIn),
    .s1Valid  (s1Valid),
    .sum      (sum),
    .sumValid (sumValid)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (startIn) stateNext = (lenIn == '0) ? OUTPUT : ACCUM;
      ACCUM:  if (beatAccept && (remaining == LEN_WIDTH'(1))) stateNext = DRAIN;
      // Once S1 is empty the only outstanding sum sits in S2 and lands in
      // acc on this same edge, so OUTPUT sees the final value.
      DRAIN:  if (!s1Valid) stateNext = OUTPUT;
      OUTPUT: if (resultReadyIn) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state     <= IDLE;
      remaining <= '0;
      acc       <= '0;
    end else begin
      state <= stateNext;
      if (startAccept) begin
        acc       <= '0;
        remaining <= lenIn;
      end else begin
        if (beatAccept) remaining <= remaining - LEN_WIDTH'(1);
        if (sumValid)   acc <= acc + sum;  // wraps modulo 2^ACC_WIDTH
      end
    end
  end

  assign busyOut        = (state != IDLE);
  assign resultValidOut = (state == OUTPUT);
  assign resultOut      = acc;

endmodule
